// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and widths for the cpu_ctrl sequencer
package cpu_pkg;

    localparam int PC_W    = 6;
    localparam int DATA_W  = 6;
    localparam int INSTR_W = 12;
    localparam int NREGS   = 8;

    typedef enum logic [2:0] {
        OP_HALT = 3'd0,
        OP_LDI  = 3'd1,
        OP_ADD  = 3'd2,
        OP_ADI  = 3'd3,
        OP_MUL  = 3'd4,
        OP_CMPJ = 3'd5,
        OP_JMP  = 3'd6,
        OP_NOP  = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } ctrl_state_e;

    typedef struct packed {
        opcode_e    op;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [2:0] rd;
    } instr_t;

    // Opcodes whose ALU result is committed to R[RD]
    function automatic logic is_write(input opcode_e op);
        return op inside {OP_LDI, OP_ADD, OP_ADI, OP_MUL};
    endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// rtl/cpu_ctrl_if.sv - instruction-memory and ALU signal bundle for cpu_ctrl
interface cpu_ctrl_if;
    import cpu_pkg::*;

    logic                 imem_rd;
    logic [PC_W-1:0]      imem_addr;
    logic [INSTR_W-1:0]   imem_data;
    logic                 imem_valid;
    logic [2:0]           alu_op;
    logic [2:0]           alu_ra;
    logic [2:0]           alu_rb;
    logic [2:0]           alu_rd;
    logic [DATA_W-1:0]    alu_a;
    logic [DATA_W-1:0]    alu_b;
    logic [DATA_W-1:0]    alu_d;

    modport master (
        output imem_rd, imem_addr, alu_op, alu_ra, alu_rb, alu_rd, alu_a, alu_b,
        input  imem_data, imem_valid, alu_d
    );

    modport slave (
        input  imem_rd, imem_addr, alu_op, alu_ra, alu_rb, alu_rd, alu_a, alu_b,
        output imem_data, imem_valid, alu_d
    );

endinterface

// File: rtl/cpu_ctrl_reg_file.sv
// rtl/cpu_ctrl_reg_file.sv - 8x6 register file, two async read ports, one sync write port
module reg_file
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        ra_addr,
    input  logic [2:0]        rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [2:0]        wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs [NREGS];

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

endmodule

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - fetch/decode/exec sequencer and writeback; CPU_CTRL_RETIRE_CNT_EN adds retire_cnt
module cpu_ctrl
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    cpu_ctrl_if.master      bus,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted
`ifdef CPU_CTRL_RETIRE_CNT_EN
    ,
    output logic [15:0]     retire_cnt
`endif
);

    ctrl_state_e       state;
    instr_t            ir;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic              we;
    logic [PC_W-1:0]   pc_next;

    assign bus.imem_addr = pc;

    // Writeback uses alu_rd latched in DECODE, so the write lands on the EXEC edge
    assign we = (state == ST_EXEC) && is_write(opcode_e'(bus.alu_op));

    reg_file u_rf (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (ir.ra),
        .rb_addr (ir.rb),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .we      (we),
        .wa      (bus.alu_rd),
        .wd      (bus.alu_d)
    );

    always_comb begin
        pc_next = pc + PC_W'(1);
        case (opcode_e'(bus.alu_op))
            OP_CMPJ: if (bus.alu_a >= bus.alu_b) pc_next = PC_W'(bus.alu_rd);
            OP_JMP:  pc_next = PC_W'(bus.alu_d);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc          <= '0;
            ir          <= '0;
            bus.imem_rd <= 1'b0;
            bus.alu_op  <= '0;
            bus.alu_ra  <= '0;
            bus.alu_rb  <= '0;
            bus.alu_rd  <= '0;
            bus.alu_a   <= '0;
            bus.alu_b   <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_FETCH;
                        pc          <= '0;
                        bus.imem_rd <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (bus.imem_valid) begin
                        ir          <= bus.imem_data;
                        bus.imem_rd <= 1'b0;
                        state       <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    bus.alu_op <= ir.op;
                    bus.alu_ra <= ir.ra;
                    bus.alu_rb <= ir.rb;
                    bus.alu_rd <= ir.rd;
                    bus.alu_a  <= ra_data;
                    bus.alu_b  <= rb_data;
                    state      <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (opcode_e'(bus.alu_op) == OP_HALT) begin
                        state  <= ST_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        pc          <= pc_next;
                        bus.imem_rd <= 1'b1;
                        state       <= ST_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CPU_CTRL_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (state == ST_EXEC && retire_cnt != 16'hFFFF) begin
            retire_cnt <= retire_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - scoreboard bench for cpu_ctrl with behavioural imem and ALU
module tb_cpu_ctrl;
    import cpu_pkg::*;

    typedef struct packed {
        logic [2:0] op;
        logic [5:0] a;
        logic [5:0] b;
        logic [5:0] pc;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [5:0] pc;
    logic       busy;
    logic       halted;
`ifdef CPU_CTRL_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    cpu_ctrl_if ifc ();

    cpu_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bus    (ifc.master),
        .pc     (pc),
        .busy   (busy),
        .halted (halted)
`ifdef CPU_CTRL_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [11:0] prog [64];
    int          stall = 0;
    int          wcnt = 0;
    logic [11:0] prod;

    always_comb begin
        ifc.imem_valid = ifc.imem_rd && (wcnt >= stall);
        ifc.imem_data  = prog[ifc.imem_addr];
    end

    always @(posedge clk) wcnt <= (ifc.imem_rd && !ifc.imem_valid) ? wcnt + 1 : 0;

    always_comb begin
        prod = {6'b0, ifc.alu_a} * {6'b0, ifc.alu_b};
        case (ifc.alu_op)
            3'd1:    ifc.alu_d = {ifc.alu_ra, ifc.alu_rb};
            3'd2:    ifc.alu_d = ifc.alu_a + ifc.alu_b;
            3'd3:    ifc.alu_d = ifc.alu_a + {3'b0, ifc.alu_rb};
            3'd4:    ifc.alu_d = prod[5:0];
            3'd6:    ifc.alu_d = {ifc.alu_ra, ifc.alu_rb};
            default: ifc.alu_d = 6'd0;
        endcase
    end

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   errors = 0;
    int   checks = 0;

    // Monitor: second non-FETCH busy cycle is EXEC; pc is captured the cycle after
    int         phase = 0;
    bit         have = 0;
    logic [2:0] cur_op;
    logic [5:0] cur_a, cur_b;

    always @(negedge clk) begin
        if (reset) begin
            phase <= 0;
            have  <= 0;
        end else begin
            if (have) obs_q.push_back({cur_op, cur_a, cur_b, pc});
            have <= 0;
            if (busy && !ifc.imem_rd) begin
                if (phase == 1) begin
                    cur_op <= ifc.alu_op;
                    cur_a  <= ifc.alu_a;
                    cur_b  <= ifc.alu_b;
                    have   <= 1;
                    phase  <= 0;
                end else begin
                    phase <= phase + 1;
                end
            end else begin
                phase <= 0;
            end
        end
    end

    logic [5:0] mregs [8];

    function automatic logic [11:0] ins(input logic [2:0] op, ra, rb, rd);
        return {op, ra, rb, rd};
    endfunction

    task automatic model_run();
        logic [5:0]  mpc, a, b, npc;
        logic [11:0] w, p;
        logic [2:0]  op, ra, rb, rd;
        mpc = 6'd0;
        for (int s = 0; s < 64; s++) begin
            w = prog[mpc];
            {op, ra, rb, rd} = w;
            a = mregs[ra];
            b = mregs[rb];
            npc = mpc + 6'd1;
            case (op)
                3'd0: npc = mpc;
                3'd1: mregs[rd] = {ra, rb};
                3'd2: mregs[rd] = a + b;
                3'd3: mregs[rd] = a + {3'b0, rb};
                3'd4: begin p = {6'b0, a} * {6'b0, b}; mregs[rd] = p[5:0]; end
                3'd5: if (a >= b) npc = {3'b0, rd};
                3'd6: npc = {ra, rb};
                default: ;
            endcase
            exp_q.push_back({op, a, b, npc});
            if (op == 3'd0) break;
            mpc = npc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        stall = 0;
        for (int i = 0; i < 64; i++) prog[i] = 12'h000;
        for (int i = 0; i < 8; i++) mregs[i] = 6'd0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        obs_q.delete();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_obs(output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (obs_q.size() > 0) begin
                ok = 1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({pc, busy, halted, ifc.imem_rd} !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl got pc=%0d busy=%b halted=%b imem_rd=%b, want all 0", pc, busy, halted, ifc.imem_rd);
        end
        checks++;
        if ({ifc.alu_op, ifc.alu_ra, ifc.alu_rb, ifc.alu_rd} !== 12'd0) begin
            errors++;
            $display("FAIL reset_alu_fields got %h want 000", {ifc.alu_op, ifc.alu_ra, ifc.alu_rb, ifc.alu_rd});
        end
        checks++;
        if ({ifc.alu_a, ifc.alu_b} !== 12'd0) begin
            errors++;
            $display("FAIL reset_operands got a=%0d b=%0d want 0 0", ifc.alu_a, ifc.alu_b);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ifc.imem_rd !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start got busy=%b imem_rd=%b want 0 0", busy, ifc.imem_rd);
        end
    endtask

    task automatic test_ldi();
        bit ok;
        rec_t e, o;
        do_reset();
        prog[0] = ins(3'd1, 3'd0, 3'd5, 3'd1);
        prog[1] = ins(3'd2, 3'd1, 3'd1, 3'd2);
        prog[2] = ins(3'd0, 3'd1, 3'd2, 3'd0);
        model_run();
        pulse_start();
        checks++;
        if (ifc.imem_rd !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ldi_fetch got imem_rd=%b busy=%b want 1 1", ifc.imem_rd, busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (pc !== 6'd0) begin
            errors++;
            $display("FAIL ldi_pc_cycle2 got %0d want 0", pc);
        end
        @(negedge clk);
        checks++;
        if (pc !== 6'd1) begin
            errors++;
            $display("FAIL ldi_pc_cycle3 got %0d want 1", pc);
        end
        while (exp_q.size() > 0) begin
            wait_obs(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL ldi_timeout no retire, want %h", exp_q[0]); exp_q.delete(); end
            else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL ldi_retire got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_add_mul();
        bit ok;
        rec_t e, o;
        do_reset();
        prog[0] = ins(3'd1, 3'd1, 3'd0, 3'd1);
        prog[1] = ins(3'd2, 3'd1, 3'd1, 3'd2);
        prog[2] = ins(3'd4, 3'd2, 3'd1, 3'd3);
        prog[3] = ins(3'd3, 3'd3, 3'd3, 3'd4);
        prog[4] = ins(3'd0, 3'd2, 3'd3, 3'd0);
        model_run();
        pulse_start();
        while (exp_q.size() > 0) begin
            wait_obs(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL addmul_timeout no retire, want %h", exp_q[0]); exp_q.delete(); end
            else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL addmul_retire got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_cmpj();
        bit ok;
        rec_t e, o;
        do_reset();
        prog[0] = ins(3'd1, 3'd0, 3'd5, 3'd1);
        prog[1] = ins(3'd1, 3'd0, 3'd3, 3'd2);
        prog[2] = ins(3'd5, 3'd1, 3'd2, 3'd6);
        prog[6] = ins(3'd5, 3'd2, 3'd1, 3'd0);
        prog[7] = ins(3'd0, 3'd1, 3'd2, 3'd0);
        model_run();
        pulse_start();
        while (exp_q.size() > 0) begin
            wait_obs(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL cmpj_timeout no retire, want %h", exp_q[0]); exp_q.delete(); end
            else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL cmpj_retire got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_jmp_wrap();
        bit ok;
        rec_t e, o;
        do_reset();
        prog[0]  = ins(3'd5, 3'd1, 3'd2, 3'd3);
        prog[1]  = ins(3'd0, 3'd0, 3'd0, 3'd0);
        prog[3]  = ins(3'd1, 3'd0, 3'd1, 3'd2);
        prog[4]  = ins(3'd6, 3'd7, 3'd7, 3'd0);
        prog[63] = ins(3'd7, 3'd0, 3'd0, 3'd0);
        model_run();
        pulse_start();
        while (exp_q.size() > 0) begin
            wait_obs(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL jmp_timeout no retire, want %h", exp_q[0]); exp_q.delete(); end
            else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL jmp_retire got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_stall_halt();
        bit ok;
        rec_t e, o;
        do_reset();
        stall = 4;
        prog[0] = ins(3'd0, 3'd0, 3'd0, 3'd0);
        model_run();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ifc.imem_rd !== 1'b1 || ifc.imem_addr !== 6'd0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got rd=%b addr=%0d busy=%b want 1 0 1", i, ifc.imem_rd, ifc.imem_addr, busy);
            end
            @(negedge clk);
        end
        while (exp_q.size() > 0) begin
            wait_obs(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL halt_timeout no retire, want %h", exp_q[0]); exp_q.delete(); end
            else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL halt_retire got %h want %h", o, e); end
            end
        end
        for (int i = 0; i < 20; i++) begin
            start = (i % 5 == 0);
            @(negedge clk);
            checks++;
            if (halted !== 1'b1 || busy !== 1'b0 || pc !== 6'd0 || ifc.imem_rd !== 1'b0) begin
                errors++;
                $display("FAIL halt_sticky cycle %0d got halted=%b busy=%b pc=%0d rd=%b want 1 0 0 0", i, halted, busy, pc, ifc.imem_rd);
            end
        end
        start = 1'b0;
`ifdef CPU_CTRL_RETIRE_CNT_EN
        checks++;
        if (retire_cnt !== 16'd1) begin
            errors++;
            $display("FAIL retire_cnt got %0d want 1", retire_cnt);
        end
`endif
    endtask

    task automatic test_reset_exec();
        bit ok;
        rec_t e, o;
        do_reset();
        prog[0] = ins(3'd1, 3'd0, 3'd5, 3'd1);
        prog[1] = ins(3'd2, 3'd1, 3'd1, 3'd1);
        prog[2] = ins(3'd0, 3'd0, 3'd0, 3'd0);
        pulse_start();
        repeat (5) @(negedge clk);
        checks++;
        if (ifc.alu_op !== 3'd2 || ifc.alu_a !== 6'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_exec_setup got op=%0d a=%0d busy=%b want 2 5 1", ifc.alu_op, ifc.alu_a, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({pc, busy, halted, ifc.imem_rd, ifc.alu_op, ifc.alu_ra, ifc.alu_rb, ifc.alu_rd, ifc.alu_a, ifc.alu_b} !== 33'd0) begin
            errors++;
            $display("FAIL rst_exec_outputs got pc=%0d busy=%b rd=%b op=%0d a=%0d b=%0d want all 0", pc, busy, ifc.imem_rd, ifc.alu_op, ifc.alu_a, ifc.alu_b);
        end
        reset = 1'b0;
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < 8; i++) mregs[i] = 6'd0;
        prog[0] = ins(3'd2, 3'd1, 3'd1, 3'd2);
        prog[1] = ins(3'd0, 3'd1, 3'd1, 3'd0);
        model_run();
        pulse_start();
        checks++;
        if (pc !== 6'd0 || ifc.imem_rd !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_restart got pc=%0d rd=%b busy=%b want 0 1 1", pc, ifc.imem_rd, busy);
        end
        while (exp_q.size() > 0) begin
            wait_obs(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rst_timeout no retire, want %h", exp_q[0]); exp_q.delete(); end
            else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL rst_retire got %h want %h", o, e); end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ldi();
        test_add_mul();
        test_cmpj();
        test_jmp_wrap();
        test_stall_halt();
        test_reset_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
- Instruction sequencer and writeback controller for the 6-bit, 8-opcode datapath.
- Fetches 12-bit instructions, decodes them into op/RA/RB/RD fields, and reads operands from an internal 8x6 register file.
- Drives those fields and operands into the ALU, then consumes the ALU result. The result goes to register writeback or to the next-PC update.
- Sits between instruction memory and the ALU; it is the producer of every ALU input and the consumer of its output.

Parameters:
- PC_W, 6, program counter / instruction address width
- DATA_W, 6, register and ALU data width
- NREGS, 8, register file depth (fixed by 3-bit register fields)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins execution at PC 0 from IDLE
- imem_rd  out  1  instruction read request, held until imem_valid
- imem_addr  out  PC_W  instruction address (= pc)
- imem_data  in  12  instruction word {op[11:9], RA[8:6], RB[5:3], RD[2:0]}
- imem_valid  in  1  imem_data valid this cycle
- alu_op  out  3  opcode to ALU
- alu_ra / alu_rb / alu_rd  out  3 each  raw instruction fields to ALU
- alu_a / alu_b  out  DATA_W  registered operands R[RA], R[RB]
- alu_d  in  DATA_W  ALU result (combinational from alu_* outputs)
- pc  out  PC_W  current program counter
- busy  out  1  high in FETCH/DECODE/EXEC
- halted  out  1  high in HALT state

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- Reset:
  - state = IDLE; pc = 0; all registers = 0; instruction register = 0.
  - alu_* = 0; imem_rd = 0; busy = 0; halted = 0.
- Reset has priority over every other event, including mid-FETCH; any in-flight write is discarded.
- IDLE:
  - start = 1 moves to FETCH with pc = 0.
  - start is ignored in all other states.
- FETCH:
  - imem_rd = 1 and imem_addr = pc.
  - On imem_valid = 1, latch imem_data into the instruction register and go to DECODE. Otherwise stay.
  - imem_valid while imem_rd = 0 is ignored.
- DECODE (1 cycle):
  - Register alu_op, alu_ra, alu_rb, alu_rd from the instruction register.
  - Register alu_a = R[RA] and alu_b = R[RB].
  - Go to EXEC.
- EXEC (1 cycle): sample alu_d and commit, per opcode:
  - 000 HALT: no write, pc unchanged, go to HALT.
  - 001 LDI, 010 ADD, 011 ADI, 100 MUL: R[RD] <= alu_d (ALU truncates to 6 bits); pc <= pc+1.
  - 101 CMPJ: if alu_a >= alu_b (unsigned, computed locally), pc <= {3'b0, RD}; else pc <= pc+1. No register write.
  - 110 JMP: pc <= alu_d (= {RA,RB}); no write.
  - 111 NOP: pc <= pc+1.
  - Then go to FETCH.
- Timing: minimum 3 cycles per instruction; each cycle of imem_valid delay adds one FETCH cycle.
- pc+1 wraps 63 -> 0 with no flag.
- HALT: absorbing; only reset exits. halted = 1, busy = 0.
- Register file:
  - Writes occur on the EXEC clock edge.
  - The DECODE read of the next instruction sees the committed value; no bypass is needed because DECODE never overlaps EXEC.
- A write to RD equal to RA or RB uses the old operand values (already latched in DECODE).

Optional Feature:
- Macro: CPU_CTRL_RETIRE_CNT_EN.
- With the macro defined:
  - Adds output retire_cnt, 16 bits.
  - Resets to 0 and increments by 1 on every EXEC cycle, HALT included.
  - Saturates at 16'hFFFF.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package cpu_pkg holds:
  - opcode_e enum (HALT, LDI, ADD, ADI, MUL, CMPJ, JMP, NOP = 0..7);
  - ctrl_state_e enum;
  - localparams PC_W, DATA_W, INSTR_W = 12;
  - instr_t packed struct {op, ra, rb, rd}.
- One sub-module, reg_file: 8x6 registers, two asynchronous read ports, one synchronous write port, synchronous reset clearing all entries.

Test Plan:
- LDI chain: imem returns LDI RA=0 RB=5 RD=1 with imem_valid on the same cycle as imem_rd → R1 = 5 on EXEC edge; pc = 1 exactly 3 cycles after start.
- ADD/MUL overflow:
  - R1 = 8 via LDI, then ADD RD=2 RA=1 RB=1 → R2 = 16.
  - Then MUL RD=3 RA=2 RB=1 (16*8 = 128) → R3 = 0.
- CMPJ both paths:
  - R1 = 5, R2 = 3; CMPJ RA=1 RB=2 RD=6 → pc = 6.
  - Swapped RA/RB → pc = previous+1.
- JMP and wrap:
  - JMP RA=7 RB=7 → pc = 63.
  - NOP at 63 → pc = 0.
- Fetch stall then HALT: imem_valid delayed 4 cycles → imem_rd held, imem_addr stable, busy = 1. The instruction is HALT → halted = 1 and stays high for 20 cycles; start pulses are ignored.
- Reset mid-EXEC of ADD → R[RD] is not written; all outputs return to reset values on the next edge; restart with start reaches pc = 0 and FETCH.
